inv_shift_rows_ser: RTL and testbench
=====================================

# inv_shift_rows_ser

Byte-serial InvShiftRows stage for the AES decryption path. Accepts a 128-bit cipher state as 16 bytes over a valid/ready stream and assembles them. Emits the InvShiftRows-permuted block as one 128-bit word over a second valid/ready handshake. A one-block holding register lets assembly of block N+1 overlap with draining of block N. It sits between the byte-wide host data path and the 128-bit decryption round datapath, mirroring the encryption-side ShiftRows.

## Interface
- INVERT, default 1; 1 = InvShiftRows (decrypt), 0 = forward ShiftRows (loopback and self-test only)
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all buffered data
- in_byte  input  8  next state byte
- in_valid  input  1  in_byte is valid
- in_ready  output  1  block can accept in_byte this cycle
- out_block  output  128  permuted state
- out_valid  output  1  out_block holds a complete block
- out_ready  input  1  consumer accepts out_block this cycle
- byte_cnt  output  5  bytes held in the assembly buffer, 0..16

## Operation
- Byte ordering:
  - Byte k (0..15) occupies bits [127-8k -: 8], with k = 4c + r (column c, row r).
  - First accepted byte is k=0; the 16th is k=15.
- Permutation, with out(r,c) and in(r,c) as bytes:
  - INVERT=1: out(r,c) = in(r,(c-r) mod 4).
  - INVERT=0: out(r,c) = in(r,(c+r) mod 4).
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- State machine, two states: FILL and FULL.
  - FILL:
    - in_ready=1.
    - Each input transfer writes byte byte_cnt and increments byte_cnt.
    - On the 16th byte (byte_cnt==15), if the output slot is free or drains in the same cycle (!out_valid || out_ready), load out_block with the permutation of the 15 buffered bytes plus in_byte, set out_valid=1, set byte_cnt=0, stay in FILL.
    - Otherwise store the byte, set byte_cnt=16, go to FULL.
  - FULL:
    - in_ready=0.
    - On an output transfer, load out_block with the permutation of the assembly buffer, keep out_valid=1, set byte_cnt=0, go to FILL.
  - Output transfer with no new block to load: out_valid clears to 0.
- out_block is held stable while out_valid && !out_ready.
- flush=1:
  - At the next edge: byte_cnt=0, state FILL, out_valid=0.
  - Overrides every simultaneous input or output transfer. A transfer that coincides with flush is discarded.
  - out_block contents are don't-care after flush.
- in_byte is ignored whenever in_ready=0.

## Timing
- Reset (n_rst low, asynchronous):
  - out_block = 128'h0, out_valid=0, byte_cnt=0, state FILL, in_ready=1.
  - The assembly buffer is cleared to zero.
- Latency: out_valid rises on the edge that accepts the 16th byte; the block is visible the cycle after that byte is presented.
- Throughput: with out_ready held high, one block per 16 cycles, with no bubble between blocks.
- Backpressure: with out_ready low, at most one complete block is held in the output register and one in the assembly buffer. in_ready falls the cycle after the 32nd outstanding byte is accepted.
- in_ready and byte_cnt are registered-state outputs only. There is no combinational path from out_ready to in_ready; in FULL, in_ready reasserts one cycle after the output transfer.
- Reset asserted mid-block discards partial data immediately. The first byte accepted after reset is k=0.

## Test plan
- INVERT=1, out_ready=1, bytes 0x00..0x0F streamed back-to-back:
  - out_valid rises after the 16th byte, for exactly one cycle.
  - out_block = 128'h000D0A07_04010E0B_0805020F_0C090603.
- INVERT=0, same stream:
  - out_block = 128'h00050A0F_04090E03_080D0207_0C01060B.
  - Feeding this block back byte-wise through an INVERT=1 instance returns 0x00..0x0F.
- out_ready=0, 40 bytes offered:
  - in_ready drops after 32 bytes accepted, with byte_cnt=16 and out_valid=1 holding block 1 stable.
  - Raising out_ready for one cycle loads block 2, and in_ready returns the next cycle.
- 16th byte accepted in the same cycle as an output transfer of the previous block:
  - New block loaded with no lost or duplicated block.
  - out_valid stays 1 and the state remains FILL.
- flush:
  - flush asserted after 7 bytes with in_valid also high: byte_cnt=0 and out_valid=0 next cycle.
  - The next 16 bytes form a correct fresh block.
- n_rst pulsed low mid-block and mid-drain:
  - All outputs take their reset values asynchronously.
  - Normal operation resumes from byte k=0.

Source files
------------

// File: rtl/inv_shift_rows_ser.sv
// Byte-serial (Inv)ShiftRows: assembles 16 bytes into a block and presents the
// permuted 128-bit state. A second block can be assembled while the first waits.
module inv_shift_rows_ser #(
  parameter bit INVERT = 1'b1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         flush,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   byte_cnt
);

  typedef enum logic {FILL, FULL} state_e;

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] asm_q, asm_d;
  logic [127:0] out_block_q, out_block_d;
  logic         out_valid_q, out_valid_d;

  logic         in_xfer;
  logic         out_xfer;
  logic [127:0] asm_wr;
  int unsigned  wr_idx;

  // Gather form: each output byte (r,c) pulls from column (c -/+ r) mod 4 of row r.
  function automatic logic [127:0] permute(input logic [127:0] s);
    logic [127:0] p;
    int unsigned  src_c;
    p = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        src_c = INVERT ? ((c + 4 - r) % 4) : ((c + r) % 4);
        p[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src_c + r) -: 8];
      end
    end
    return p;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_block_d = out_block_q;
    out_valid_d = out_valid_q;

    in_xfer  = in_valid && (state_q == FILL);
    out_xfer = out_valid_q && out_ready;

    wr_idx = {28'd0, cnt_q[3:0]};
    asm_wr = asm_q;
    asm_wr[127 - 8*wr_idx -: 8] = in_byte;

    if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      state_d     = FILL;
      cnt_d       = '0;
      asm_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_xfer) begin
            if (cnt_q == 5'd15) begin
              if (!out_valid_q || out_ready) begin
                out_block_d = permute(asm_wr);
                out_valid_d = 1'b1;
                cnt_d       = '0;
              end else begin
                asm_d   = asm_wr;
                cnt_d   = 5'd16;
                state_d = FULL;
              end
            end else begin
              asm_d = asm_wr;
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        FULL: begin
          // out_valid is always set here, so out_ready alone marks the transfer.
          if (out_xfer) begin
            out_block_d = permute(asm_q);
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      asm_q       <= '0;
      out_block_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_block_q <= out_block_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign byte_cnt  = cnt_q;
  assign out_block = out_block_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inv_shift_rows_ser.sv
// Directed bench for inv_shift_rows_ser: scoreboard of expected blocks pushed on
// the 16th accepted byte, popped on each output transfer.
module tb_inv_shift_rows_ser;

  logic         clk;
  logic         n_rst;
  logic         flush;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   byte_cnt;

  logic         fwd_in_ready;
  logic [127:0] fwd_out_block;
  logic         fwd_out_valid;
  logic         fwd_out_ready;
  logic [4:0]   fwd_byte_cnt;

  int unsigned  n_assert = 0;
  int unsigned  n_fail   = 0;
  int unsigned  cycle_cnt = 0;
  int unsigned  tb_k = 0;
  logic [7:0]   acc [16];
  logic [127:0] exp_q [$];
  logic [127:0] fwd_blk;
  logic [127:0] snap;
  int unsigned  acc_n;
  int unsigned  t0;

  inv_shift_rows_ser #(.INVERT(1'b1)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (flush),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .byte_cnt  (byte_cnt)
  );

  inv_shift_rows_ser #(.INVERT(1'b0)) fwd (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (flush),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (fwd_in_ready),
    .out_block (fwd_out_block),
    .out_valid (fwd_out_valid),
    .out_ready (fwd_out_ready),
    .byte_cnt  (fwd_byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt++;

  // Scatter form of InvShiftRows: input column c of row r lands in column c+r.
  function automatic logic [127:0] model(input logic [7:0] a [16]);
    logic [127:0] o;
    int r;
    int cd;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      r  = k % 4;
      cd = ((k / 4) + r) % 4;
      o[127 - 8*(4*cd + r) -: 8] = a[k];
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] b);
    acc[tb_k] = b;
    if (tb_k == 15) begin
      exp_q.push_back(model(acc));
      tb_k = 0;
    end else begin
      tb_k++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned waited;
    bit done;
    waited = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !flush && n_rst) begin
        accept(b);
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done) begin
        waited++;
        if (waited >= 64) begin
          n_assert++;
          n_fail++;
          $error("FAIL send_timeout: observed no acceptance after %0d cycles expected acceptance", waited);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (n_rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL sb_underflow: observed block %h expected none", out_block);
      end else begin
        check("sb_block", out_block, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_byte = '0;
    out_ready = 1'b0; fwd_out_ready = 1'b1;
    #3;
    check("rst_out_block", out_block, '0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_byte_cnt",  128'(byte_cnt), 128'd0);
    check("rst_in_ready",  128'(in_ready), 128'd1);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Known vector, INVERT=1 and INVERT=0 in parallel
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    check("inv_vec", out_block, 128'h000D0A07_04010E0B_0805020F_0C090603);
    check("inv_valid_rise", 128'(out_valid), 128'd1);
    check("fwd_vec", fwd_out_block, 128'h00050A0F_04090E03_080D0207_0C01060B);
    fwd_blk = fwd_out_block;
    idle(1);
    check("inv_valid_pulse", 128'(out_valid), 128'd0);

    // Loopback forward block through the inverse instance
    for (int k = 0; k < 16; k++) send_byte(fwd_blk[127 - 8*k -: 8]);
    check("loopback", out_block, 128'h00010203_04050607_08090A0B_0C0D0E0F);
    idle(2);

    // Back-to-back throughput
    t0 = cycle_cnt;
    for (int i = 0; i < 32; i++) send_byte(8'($urandom_range(0, 255)));
    check("throughput_cycles", 128'(cycle_cnt - t0), 128'd32);
    idle(2);

    // Backpressure: 40 bytes offered, 32 fit
    out_ready = 1'b0;
    acc_n = 0;
    snap = '0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (in_ready) begin
        accept(in_byte);
        acc_n++;
      end
      if (i == 20) snap = out_block;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", 128'(acc_n), 128'd32);
    check("bp_byte_cnt", 128'(byte_cnt), 128'd16);
    check("bp_in_ready", 128'(in_ready), 128'd0);
    check("bp_out_valid", 128'(out_valid), 128'd1);
    check("bp_block1", out_block, exp_q[0]);
    check("bp_block1_stable", out_block, snap);
    out_ready = 1'b1;
    #1;
    check("bp_no_comb_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_block2", out_block, exp_q[0]);
    check("bp_block2_valid", 128'(out_valid), 128'd1);
    check("bp_cnt_after", 128'(byte_cnt), 128'd0);
    check("bp_ready_back", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    idle(2);
    check("bp_drained", 128'(out_valid), 128'd0);

    // 16th byte coincides with output transfer of previous block
    out_ready = 1'b0;
    for (int i = 0; i < 31; i++) send_byte(8'($urandom_range(0, 255)));
    out_ready = 1'b1;
    send_byte(8'($urandom_range(0, 255)));
    check("same_valid", 128'(out_valid), 128'd1);
    check("same_in_ready", 128'(in_ready), 128'd1);
    check("same_byte_cnt", 128'(byte_cnt), 128'd0);
    check("same_block", out_block, exp_q[0]);
    idle(2);
    check("same_sb_empty", 128'(exp_q.size()), 128'd0);

    // Flush with a pending block and 7 partial bytes
    out_ready = 1'b0;
    for (int i = 0; i < 23; i++) send_byte(8'($urandom_range(0, 255)));
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    tb_k = 0;
    check("flush_byte_cnt", 128'(byte_cnt), 128'd0);
    check("flush_out_valid", 128'(out_valid), 128'd0);
    check("flush_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)));
    check("flush_fresh", out_block, exp_q[0]);
    idle(2);

    // Asynchronous reset mid-drain and mid-block
    out_ready = 1'b0;
    for (int i = 0; i < 21; i++) send_byte(8'($urandom_range(0, 255)));
    #1;
    n_rst = 1'b0;
    #1;
    check("arst_out_block", out_block, '0);
    check("arst_out_valid", 128'(out_valid), 128'd0);
    check("arst_byte_cnt", 128'(byte_cnt), 128'd0);
    check("arst_in_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b0;
    exp_q.delete();
    tb_k = 0;
    @(negedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    check("arst_resume", out_block, 128'h000D0A07_04010E0B_0805020F_0C090603);
    idle(2);

    check("final_sb_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
